sym_seq_fsm: RTL and testbench

SYM_SEQ_FSM -- requirements
Module: sym_seq_fsm

---
 rtl/sym_seq_fsm_pkg.sv | 24 ++
 rtl/sym_seq_fsm_sat_counter.sv | 26 ++
 rtl/sym_seq_fsm.sv | 97 +++++++++
 tb/tb_sym_seq_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_seq_fsm_pkg.sv
// +----------------------------------------------------------------+
// | sym_seq_fsm_pkg : shared encodings and defaults for sym_seq_fsm |
// | Revision 1.0                                                    |
// +----------------------------------------------------------------+
`default_nettype none

package sym_seq_fsm_pkg;

   localparam int DEF_IN_W  = 2;
   localparam int DEF_LEN   = 4;
   localparam int DEF_CNT_W = 8;

   typedef enum logic {
      MODE_NONOVL = 1'b0,
      MODE_OVL    = 1'b1
   } mode_e;

   function automatic int st_width(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sym_seq_fsm_sat_counter.sv
// +----------------------------------------------------------------+
// | sat_counter : up-counter that sticks at its all-ones value      |
// | Revision 1.0                                                    |
// +----------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sym_seq_fsm.sv
// +----------------------------------------------------------------+
// | sym_seq_fsm : programmable symbol-sequence detector with count  |
// | Revision 1.0                                                    |
// +----------------------------------------------------------------+
`default_nettype none

module sym_seq_fsm
   import sym_seq_fsm_pkg::*;
#(
   parameter  int IN_W  = DEF_IN_W,
   parameter  int LEN   = DEF_LEN,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int ST_W  = st_width(LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in,
   input  logic             in_valid,
   input  logic             mode,
   input  logic             load,
   input  logic [ST_W-1:0]  load_idx,
   input  logic [IN_W-1:0]  load_sym,
   output logic [ST_W-1:0]  state,
   output logic             match,
   output logic [CNT_W-1:0] match_count
);

   logic [IN_W-1:0] r_pat [LEN];
   logic [ST_W-1:0] r_state;
   logic [ST_W-1:0] w_state_nxt;
   logic            r_match;
   logic            w_match_nxt;
   logic            w_hit_cur;
   logic            w_hit_first;

   // Out-of-range slot indices match no entry, so they write nothing.
   genvar gi;
   generate
      for (gi = 0; gi < LEN; gi++) begin : g_pat
         always_ff @(posedge clk) begin
            if (rst) begin
               r_pat[gi] <= '0;
            end else if (load && (int'(load_idx) == gi)) begin
               r_pat[gi] <= load_sym;
            end
         end
      end
   endgenerate

   assign w_hit_cur   = (in == r_pat[r_state]);
   assign w_hit_first = (in == r_pat[0]);

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = 1'b0;
      if (load) begin
         w_state_nxt = '0;
      end else if (in_valid) begin
         if (w_hit_cur) begin
            if (r_state == ST_W'(LEN - 1)) begin
               w_match_nxt = 1'b1;
               w_state_nxt = ((mode_e'(mode) == MODE_OVL) && w_hit_first) ? ST_W'(1) : '0;
            end else begin
               w_state_nxt = r_state + ST_W'(1);
            end
         end else begin
            // Failed symbol may itself start a new attempt.
            w_state_nxt = w_hit_first ? ST_W'(1) : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= '0;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_match <= w_match_nxt;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_match_nxt),
      .count (match_count)
   );

   assign state = r_state;
   assign match = r_match;

endmodule

`default_nettype wire

// File: tb/tb_sym_seq_fsm.sv
// +----------------------------------------------------------------+
// | tb_sym_seq_fsm : directed self-checking bench for sym_seq_fsm   |
// | Revision 1.0                                                    |
// +----------------------------------------------------------------+
`default_nettype none

module tb_sym_seq_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] in = '0;
   logic       in_valid = 1'b0;
   logic       mode = 1'b0;
   logic       load = 1'b0;
   logic [1:0] load_idx = '0;
   logic [1:0] load_sym = '0;

   logic [1:0] state;
   logic       match;
   logic [7:0] match_count;
   logic [1:0] state2;
   logic       match2;
   logic [1:0] match_count2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sym_seq_fsm dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .mode(mode),
      .load(load), .load_idx(load_idx), .load_sym(load_sym),
      .state(state), .match(match), .match_count(match_count)
   );

   sym_seq_fsm #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .mode(mode),
      .load(load), .load_idx(load_idx), .load_sym(load_sym),
      .state(state2), .match(match2), .match_count(match_count2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; load = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic load_pat(input logic [1:0] p0, p1, p2, p3);
      logic [1:0] p [4];
      p = '{p0, p1, p2, p3};
      for (int i = 0; i < 4; i++) begin
         load = 1'b1; load_idx = 2'(i); load_sym = p[i];
         step();
      end
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in = 2'd0; load = 1'b1; load_idx = 2'd0; load_sym = 2'd3;
      step();
      rst = 1'b0; load = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++;
      if (match !== 1'b0) begin n_err++; $display("FAIL reset_match: got %0d expected 0", match); end
      n_cmp++;
      if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", match_count); end
      // Pattern must be all zeros after reset: four 0 symbols complete it.
      in_valid = 1'b1; in = 2'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (match !== (i == 3)) begin n_err++; $display("FAIL reset_pat_match[%0d]: got %0d expected %0d", i, match, (i == 3)); end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (match_count !== 8'd1) begin n_err++; $display("FAIL reset_pat_count: got %0d expected 1", match_count); end
   endtask

   task automatic test_nonoverlap();
      logic [1:0] s  [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
      logic [1:0] es [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
      logic       em [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      load_pat(2'd0, 2'd1, 2'd2, 2'd1);
      mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in = s[i]; in_valid = 1'b1;
         step();
         n_cmp++;
         if (state !== es[i]) begin n_err++; $display("FAIL nonovl_state[%0d]: got %0d expected %0d", i, state, es[i]); end
         n_cmp++;
         if (match !== em[i]) begin n_err++; $display("FAIL nonovl_match[%0d]: got %0d expected %0d", i, match, em[i]); end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (match_count !== 8'd1) begin n_err++; $display("FAIL nonovl_count: got %0d expected 1", match_count); end
   endtask

   task automatic test_ones(input logic m);
      logic [1:0] es_ovl [8] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
      logic       em_ovl [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] es_non [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic       em_non [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] es;
      logic       em;
      do_reset();
      load_pat(2'd1, 2'd1, 2'd1, 2'd1);
      mode = m;
      for (int i = 0; i < 8; i++) begin
         in = 2'd1; in_valid = 1'b1;
         step();
         es = m ? es_ovl[i] : es_non[i];
         em = m ? em_ovl[i] : em_non[i];
         n_cmp++;
         if (state !== es) begin n_err++; $display("FAIL ones_m%0d_state[%0d]: got %0d expected %0d", m, i, state, es); end
         n_cmp++;
         if (match !== em) begin n_err++; $display("FAIL ones_m%0d_match[%0d]: got %0d expected %0d", m, i, match, em); end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (match_count !== 8'd2) begin n_err++; $display("FAIL ones_m%0d_count: got %0d expected 2", m, match_count); end
   endtask

   task automatic test_hold_and_restart();
      do_reset();
      load_pat(2'd0, 2'd1, 2'd2, 2'd1);
      mode = 1'b0;
      in = 2'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in = 2'd3;
      step(); step();
      n_cmp++;
      if (state !== 2'd1) begin n_err++; $display("FAIL hold_state: got %0d expected 1", state); end
      in = 2'd1; in_valid = 1'b1;
      step();
      in = 2'd0;
      step();
      // Mismatch at slot 2, but symbol equals slot 0, so progress restarts at 1.
      n_cmp++;
      if (state !== 2'd1) begin n_err++; $display("FAIL restart_state: got %0d expected 1", state); end
      in_valid = 1'b0;
   endtask

   task automatic test_load_priority();
      logic [1:0] s [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      do_reset();
      load_pat(2'd0, 2'd1, 2'd2, 2'd1);
      mode = 1'b0;
      in_valid = 1'b1;
      in = 2'd0; step();
      in = 2'd1; step();
      n_cmp++;
      if (state !== 2'd2) begin n_err++; $display("FAIL loadpri_pre_state: got %0d expected 2", state); end
      load = 1'b1; load_idx = 2'd3; load_sym = 2'd3; in = 2'd2;
      step();
      load = 1'b0;
      n_cmp++;
      if (state !== 2'd0) begin n_err++; $display("FAIL loadpri_state: got %0d expected 0", state); end
      n_cmp++;
      if (match !== 1'b0) begin n_err++; $display("FAIL loadpri_match: got %0d expected 0", match); end
      for (int i = 0; i < 4; i++) begin
         in = s[i];
         step();
         n_cmp++;
         if (match !== (i == 3)) begin n_err++; $display("FAIL loadpri_newpat_match[%0d]: got %0d expected %0d", i, match, (i == 3)); end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_saturate();
      logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      int         pulses;
      int         k;
      do_reset();
      load_pat(2'd1, 2'd1, 2'd1, 2'd1);
      mode = 1'b0;
      pulses = 0;
      k = 0;
      in = 2'd1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (match2) begin
            pulses++;
            if (k < 5) begin
               n_cmp++;
               if (match_count2 !== ec[k]) begin n_err++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, match_count2, ec[k]); end
            end
            k++;
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (pulses != 5) begin n_err++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
      n_cmp++;
      if (match_count !== 8'd5) begin n_err++; $display("FAIL sat_wide_count: got %0d expected 5", match_count); end
   endtask

   task automatic test_rst_priority();
      do_reset();
      load_pat(2'd0, 2'd1, 2'd2, 2'd1);
      mode = 1'b0;
      in_valid = 1'b1;
      in = 2'd0; step();
      in = 2'd1; step();
      in = 2'd2; step();
      n_cmp++;
      if (state !== 2'd3) begin n_err++; $display("FAIL rstpri_pre_state: got %0d expected 3", state); end
      rst = 1'b1; in = 2'd1; load = 1'b1; load_idx = 2'd0; load_sym = 2'd2;
      step();
      rst = 1'b0; load = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (match !== 1'b0) begin n_err++; $display("FAIL rstpri_match: got %0d expected 0", match); end
      n_cmp++;
      if (state !== 2'd0) begin n_err++; $display("FAIL rstpri_state: got %0d expected 0", state); end
      n_cmp++;
      if (match_count !== 8'd0) begin n_err++; $display("FAIL rstpri_count: got %0d expected 0", match_count); end
      step();
      n_cmp++;
      if (match !== 1'b0) begin n_err++; $display("FAIL rstpri_late_match: got %0d expected 0", match); end
   endtask

   initial begin
      test_reset();
      test_nonoverlap();
      test_ones(1'b1);
      test_ones(1'b0);
      test_hold_and_restart();
      test_load_priority();
      test_saturate();
      test_rst_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
